reg_fifo: RTL and testbench
===========================

Name: reg_fifo

Overview:
- Parametrised synchronous FIFO with valid/ready handshakes on both sides. It is the buffered successor to the single-stage enable register in the shared tools library.
- Decouples producer and consumer pipeline stages in the NPC, e.g. fetch→decode and LSU request queues.
- Output is first-word-fall-through: the head entry is always presented on out_data with out_valid.
- Adds synchronous flush, occupancy count and a defined empty-output value.

Parameters:
- WIDTH, 32, data bits per entry.
- DEPTH, 4, number of entries; must be a power of two, ≥2.
- RESET_VAL, 0, value driven on out_data whenever the FIFO is empty.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous discard of all contents.
- in_valid  input  1  producer has in_data.
- in_ready  output  1  FIFO can accept an entry this cycle.
- in_data  input  WIDTH  write data.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer takes head this cycle.
- out_data  output  WIDTH  head entry, or RESET_VAL when empty.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- **State**
  - Storage is mem[DEPTH] of WIDTH bits, read pointer rd_ptr and write pointer wr_ptr (each $clog2(DEPTH) bits), and count.
  - mem is not reset; pointers and count are.
- **Reset** (rst=1 at edge): rd_ptr=wr_ptr=0, count=0. Hence out_valid=0, in_ready=1, out_data=RESET_VAL from the following cycle.
- **Priority**: rst > flush > push/pop.
- **Status outputs**
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - Both derive from registered state only. There is no combinational path from out_ready to in_ready or from in_valid to out_valid.
- **Transfers**
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - push: mem[wr_ptr] <= in_data, wr_ptr+1.
  - pop: rd_ptr+1.
  - Pointers wrap modulo DEPTH naturally (power-of-two width).
- **Count update**
  - push only: +1.
  - pop only: −1.
  - push & pop: unchanged, both pointers advance.
  - Neither: hold.
- **Latency**
  - A write into an empty FIFO appears on out_data/out_valid the next cycle. There is no same-cycle bypass.
  - The minimum in→out latency is 1 cycle.
  - Throughput is 1 entry/cycle when neither full nor empty.
- **Full** (count==DEPTH): in_ready=0, and in_valid is ignored even if out_ready=1 in the same cycle. in_ready rises the cycle after a pop.
- **Empty** (count==0): out_valid=0 and out_data=RESET_VAL. out_ready is ignored, so there is no underflow and no pointer movement.
- **Producer protocol**: in_data is sampled only on push. Holding in_valid while in_ready=0 causes no write.
- **Flush** (flush=1, rst=0)
  - Next cycle: rd_ptr=wr_ptr=0, count=0.
  - Any push or pop in the flush cycle is discarded.
  - Outputs in the flush cycle itself still reflect pre-flush state.
- **Reset mid-operation**: identical to flush in effect on state. In-flight entries are lost, with no partial update.
- **Invariants**
  - count never exceeds DEPTH or drops below 0.
  - wr_ptr − rd_ptr (mod DEPTH) == count, except when count==DEPTH, where the pointers are equal.
- Elaboration must fail (e.g. via a generate-time error) if DEPTH is not a power of two or is less than 2.

Test Plan:
1. **Reset**: assert rst 2 cycles with in_valid=1, in_data=0xAA → count=0, out_valid=0, in_ready=1, out_data=RESET_VAL (0); no entry written.
2. **Fill/drain, DEPTH=4**: push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=0 → count 1,2,3,4, in_ready=0 after the 4th, out_data=0x11. A 5th push of 0x55 is ignored. Then out_ready=1 for 4 cycles → pops 0x11,0x22,0x33,0x44 in order, final count=0, out_data=0.
3. **Simultaneous push+pop at full**: full with 0x11..0x44, in_valid=1 (0x55), out_ready=1 → only the pop occurs, count=3. Next cycle push+pop → count stays 3, out_data=0x33.
4. **Wrap-around**: stream 10 entries (0x01..0x0A) with in_valid=out_ready=1 continuously → output sequence 0x01..0x0A in order with 1-cycle latency, count never >1, pointers wrap twice.
5. **Flush**: with count=3, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, data dropped. The following push of 0x77 emerges as the first output.
6. **Reset mid-stream, WIDTH=8, RESET_VAL=0xFF**: count=2, assert rst with push+pop active → next cycle count=0 and out_data=0xFF. The subsequent push of 0x5A is read back correctly.

Source files
------------

// File: rtl/reg_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, 1-cycle minimum in->out latency.
// Backpressure: in_ready drops at full, out_valid drops at empty; both are taken only from registered state.
module reg_fifo #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("reg_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : RESET_VAL;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; a discarded push must not leave stale data behind either.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_reg_fifo.sv
module tb_reg_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance, empty value 0
    logic        rst0, fl0, iv0, ir0, ov0, or0;
    logic [31:0] id0, od0;
    logic [2:0]  cnt0;
    // 8-bit instance, empty value 0xFF
    logic        rst1, fl1, iv1, ir1, ov1, or1;
    logic [7:0]  id1, od1;
    logic [2:0]  cnt1;

    reg_fifo #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'h0)) u_dut0 (
        .clk(clk), .rst(rst0), .flush(fl0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .count(cnt0)
    );

    reg_fifo #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hFF)) u_dut1 (
        .clk(clk), .rst(rst1), .flush(fl1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] q0[$];
    logic [7:0]  q1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the queue models, advance one clock, update the models.
    task automatic tick();
        bit p, q;
        check("cnt0", 32'(cnt0), 32'(q0.size()));
        check("ov0", 32'(ov0), 32'(q0.size() != 0));
        check("ir0", 32'(ir0), 32'(q0.size() != 4));
        check("od0", od0, (q0.size() != 0) ? q0[0] : 32'h0);
        check("cnt1", 32'(cnt1), 32'(q1.size()));
        check("ov1", 32'(ov1), 32'(q1.size() != 0));
        check("ir1", 32'(ir1), 32'(q1.size() != 4));
        check("od1", 32'(od1), (q1.size() != 0) ? 32'(q1[0]) : 32'hFF);

        if (rst0 || fl0) begin
            q0.delete();
        end else begin
            p = iv0 && (q0.size() < 4);
            q = or0 && (q0.size() > 0);
            if (q) void'(q0.pop_front());
            if (p) q0.push_back(id0);
        end
        if (rst1 || fl1) begin
            q1.delete();
        end else begin
            p = iv1 && (q1.size() < 4);
            q = or1 && (q1.size() > 0);
            if (q) void'(q1.pop_front());
            if (p) q1.push_back(id1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_next;

        // Reset held two cycles while the producer tries to write
        rst0 = 1; fl0 = 0; iv0 = 1; id0 = 32'hAA; or0 = 0;
        rst1 = 1; fl1 = 0; iv1 = 1; id1 = 8'hAA;  or1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 0; rst1 = 0; iv0 = 0; iv1 = 0;
        check("rst_cnt", 32'(cnt0), 0);
        check("rst_ov", 32'(ov0), 0);
        check("rst_ir", 32'(ir0), 1);
        check("rst_od", od0, 32'h0);
        check("rst_od1", 32'(od1), 32'hFF);

        // Fill to full, extra push ignored, then drain in order
        for (int i = 0; i < 4; i++) begin
            iv0 = 1; id0 = 32'((i + 1) * 'h11);
            tick();
            check("fill_cnt", 32'(cnt0), 32'(i + 1));
        end
        check("full_ir", 32'(ir0), 0);
        check("full_head", od0, 32'h11);
        id0 = 32'h55;
        tick();
        check("overflow_cnt", 32'(cnt0), 4);
        check("overflow_head", od0, 32'h11);
        iv0 = 0; or0 = 1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", od0, 32'((i + 1) * 'h11));
            tick();
        end
        or0 = 0;
        check("drain_cnt", 32'(cnt0), 0);
        check("drain_od", od0, 32'h0);

        // Push+pop while full: only the pop happens; then a real push+pop
        for (int i = 0; i < 4; i++) begin
            iv0 = 1; id0 = 32'((i + 1) * 'h11);
            tick();
        end
        id0 = 32'h55; or0 = 1;
        tick();
        check("fullpp_cnt", 32'(cnt0), 3);
        id0 = 32'h66;
        tick();
        check("pp_cnt", 32'(cnt0), 3);
        check("pp_head", od0, 32'h33);
        iv0 = 0;
        repeat (3) tick();
        or0 = 0;

        // Continuous streaming through pointer wrap
        exp_next = 1;
        iv0 = 1; or0 = 1;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) iv0 = 0;
            id0 = 32'(i);
            if (ov0) begin
                check("stream_data", od0, 32'(exp_next));
                exp_next++;
            end
            check("stream_cnt_le1", 32'(cnt0 <= 3'd1), 1);
            tick();
        end
        or0 = 0;
        check("stream_all_out", 32'(exp_next), 11);
        check("stream_empty", 32'(cnt0), 0);

        // Flush with concurrent push and pop
        iv0 = 1;
        for (int i = 0; i < 3; i++) begin
            id0 = 32'h31 + 32'(i);
            tick();
        end
        fl0 = 1; id0 = 32'h99; or0 = 1;
        check("flush_cycle_head", od0, 32'h31);
        tick();
        fl0 = 0; iv0 = 0; or0 = 0;
        check("flush_cnt", 32'(cnt0), 0);
        check("flush_ov", 32'(ov0), 0);
        iv0 = 1; id0 = 32'h77;
        tick();
        iv0 = 0;
        check("postflush_head", od0, 32'h77);
        or0 = 1;
        tick();
        or0 = 0;

        // Reset mid-stream on the 8-bit instance
        iv1 = 1; id1 = 8'h10;
        tick();
        id1 = 8'h20;
        tick();
        check("pre_rst_cnt1", 32'(cnt1), 2);
        rst1 = 1; id1 = 8'h30; or1 = 1;
        tick();
        rst1 = 0; iv1 = 0; or1 = 0;
        check("rst1_cnt", 32'(cnt1), 0);
        check("rst1_od", 32'(od1), 32'hFF);
        iv1 = 1; id1 = 8'h5A;
        tick();
        iv1 = 0;
        check("rst1_readback", 32'(od1), 32'h5A);
        or1 = 1;
        tick();
        or1 = 0;

        // Randomised traffic with occasional flush/reset
        for (int n = 0; n < 400; n++) begin
            iv0 = 1'($urandom_range(0, 1)); id0 = $urandom;
            or0 = 1'($urandom_range(0, 1));
            fl0 = ($urandom_range(0, 15) == 0);
            rst0 = ($urandom_range(0, 63) == 0);
            iv1 = 1'($urandom_range(0, 1)); id1 = 8'($urandom);
            or1 = ($urandom_range(0, 3) == 0);
            fl1 = ($urandom_range(0, 31) == 0);
            rst1 = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst0 = 0; fl0 = 0; iv0 = 0; or0 = 0;
        rst1 = 0; fl1 = 0; iv1 = 0; or1 = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
